spi_controller: RTL and testbench

SPI mode-0 write-frame initiator, the controller side of the on-chip SPI register peripheral. It accepts one register-access request per valid/ready handshake and serialises a 16-bit frame onto sclk/ncs/copi, MSB first. All outputs are registered and slow enough to be sampled through a 2-FF synchroniser clocked by the same clk. It is used on test harnesses and by on-chip config sequencers.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_clk_div.sv | 20 ++
 rtl/spi_controller.sv | 91 +++++++++
 tb/tb_spi_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: frame layout, peripheral register map and controller state encoding
package spi_pkg;
    localparam int FRAME_BITS    = 16;
    localparam int ADDR_BITS     = 7;
    localparam int DATA_BITS     = 8;
    localparam int WRITE_BIT_IDX = 15;
    localparam logic [ADDR_BITS-1:0] REG_OUT_EN_LO = 7'h00;
    localparam logic [ADDR_BITS-1:0] REG_OUT_EN_HI = 7'h01;
    localparam logic [ADDR_BITS-1:0] REG_PWM_EN_LO = 7'h02;
    localparam logic [ADDR_BITS-1:0] REG_PWM_EN_HI = 7'h03;
    localparam logic [ADDR_BITS-1:0] REG_DUTY      = 7'h04;
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT_HI, SHIFT_LO, GAP} state_t;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: one-cycle tick every CLK_DIV clk cycles while en is high
// ports: clk, rst (sync, active-high), en, clr (sync clear), tick
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV + 1);
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(1);
    // zero means "freshly enabled": first tick lands CLK_DIV cycles after enable
    always_ff @(posedge clk) begin
        if (rst || clr || !en) cnt <= '0;
        else cnt <= cnt == '0 ? W'(CLK_DIV - 1) : tick ? W'(CLK_DIV) : cnt - W'(1);
    end
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 16-bit write-frame initiator, MSB first, registered outputs
// ports: clk, rst (sync, active-high); req_valid/req_ready handshake with req_write/req_addr/req_data;
//        sclk/ncs/copi SPI pins; busy (frame in progress); done (one-cycle completion pulse)
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int LEAD_HALVES = 1,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_data,
    output logic                 sclk,
    output logic                 ncs,
    output logic                 copi,
    output logic                 busy,
    output logic                 done
);
    localparam int LW = $clog2(LEAD_HALVES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    if (CLK_DIV < 4 || LEAD_HALVES < 1 || GAP_CYCLES < 4) begin : g_bad_params
        $error("spi_controller: CLK_DIV>=4, LEAD_HALVES>=1, GAP_CYCLES>=4 required");
    end

    state_t                state, state_n;
    logic [FRAME_BITS-1:0] frame;
    logic [4:0]            bit_cnt;
    logic [LW-1:0]         lead_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  tick, accept, fall, div_en;

    assign accept = req_valid && req_ready;
    assign fall   = state == SHIFT_HI && tick;
    assign div_en = state == LEAD || state == SHIFT_HI || state == SHIFT_LO;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (state == IDLE),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = accept ? LEAD : IDLE;
            LEAD:     state_n = tick && lead_cnt == LW'(LEAD_HALVES - 1) ? SHIFT_HI : LEAD;
            SHIFT_HI: state_n = tick ? SHIFT_LO : SHIFT_HI;
            SHIFT_LO: state_n = !tick ? SHIFT_LO : bit_cnt == 5'(FRAME_BITS) ? GAP : SHIFT_HI;
            GAP:      state_n = gap_cnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame     <= '0;
            bit_cnt   <= '0;
            lead_cnt  <= '0;
            gap_cnt   <= '0;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
            copi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            frame     <= accept ? {req_write, req_addr, req_data} : fall ? frame << 1 : frame;
            bit_cnt   <= accept ? '0 : fall ? bit_cnt + 5'd1 : bit_cnt;
            lead_cnt  <= state != LEAD ? '0 : tick ? lead_cnt + LW'(1) : lead_cnt;
            gap_cnt   <= state == GAP ? gap_cnt + GW'(1) : '0;
            sclk      <= state_n == SHIFT_HI;
            ncs       <= state_n == IDLE || state_n == GAP;
            // next bit comes from frame[14] on the fall; zeros shifted in make copi=0 after bit 0
            copi      <= accept ? req_write : fall ? frame[FRAME_BITS-2] :
                         (state_n == LEAD || state_n == SHIFT_HI || state_n == SHIFT_LO) ? copi : 1'b0;
            busy      <= state_n != IDLE;
            req_ready <= state_n == IDLE;
            done      <= state == GAP && state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed self-checking bench for spi_controller
module tb_spi_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, sclk, ncs, copi, busy, done;
    int         checks = 0;
    int         fails = 0;

    spi_controller #(.CLK_DIV(4), .LEAD_HALVES(1), .GAP_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic        sclk_q = 1'b0, ncs_q = 1'b1, copi_q = 1'b0;
    logic [15:0] cap = '0;
    logic [15:0] frames_q[$];
    int          run = 0, margin_err = 0, rises = 0, low_len = 0, hi_len = 0;
    int          last_gap = 0, last_low = 0, last_rises = 0;

    always @(negedge clk) begin
        if (ncs === 1'b0 && ncs_q === 1'b1) begin
            cap = '0;
            rises = 0;
            low_len = 0;
            last_gap = hi_len;
        end
        if (ncs === 1'b0) low_len++;
        if (ncs === 1'b1) hi_len++;
        else hi_len = 0;
        if (ncs === 1'b1 && ncs_q === 1'b0) begin
            last_low = low_len;
            last_rises = rises;
            frames_q.push_back(cap);
        end
        if (sclk === 1'b1 && sclk_q === 1'b0) begin
            cap = {cap[14:0], copi};
            rises++;
            if (run < 4) margin_err++;
        end
        if (sclk === 1'b1 && sclk_q === 1'b1 && copi !== copi_q) margin_err++;
        run = (copi === copi_q) ? run + 1 : 1;
        sclk_q = sclk;
        ncs_q = ncs;
        copi_q = copi;
    end

    task automatic tick_s;
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [6:0] a, input logic [7:0] d);
        int k = 0;
        while (req_ready !== 1'b1 && k < 400) begin
            tick_s;
            k++;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        req_data = d;
        tick_s;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 400) begin
            tick_s;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick_s;
        checks++; if (sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (ncs !== 1'b1) begin fails++; $display("FAIL reset_ncs: got %b expected 1", ncs); end
        checks++; if (copi !== 1'b0) begin fails++; $display("FAIL reset_copi: got %b expected 0", copi); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        rst = 1'b0;
        repeat (2) tick_s;
        checks++; if ({ncs, req_ready, busy} !== 3'b110) begin
            fails++; $display("FAIL idle_after_reset: got ncs/ready/busy=%b expected 110", {ncs, req_ready, busy});
        end
    endtask

    task automatic test_basic_write;
        int n;
        int base = frames_q.size();
        start(1'b1, 7'h04, 8'h80);
        req_write = 1'b0;
        req_addr = 7'h3C;
        req_data = 8'h0F;
        checks++; if ({ncs, busy, copi, req_ready} !== 4'b0110) begin
            fails++; $display("FAIL basic_first_cycle: got ncs/busy/copi/ready=%b expected 0110", {ncs, busy, copi, req_ready});
        end
        wait_done(1, n);
        checks++; if (n !== 137) begin fails++; $display("FAIL basic_done_latency: got %0d expected 137", n); end
        checks++; if ({busy, req_ready} !== 2'b01) begin
            fails++; $display("FAIL basic_done_state: got busy/ready=%b expected 01", {busy, req_ready});
        end
        tick_s;
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width: got %b expected 0", done); end
        checks++; if (frames_q.size() - base !== 1 || frames_q[base] !== 16'h8480) begin
            fails++; $display("FAIL basic_frame: got %0d frames first %h expected 1 frame 8480", frames_q.size() - base, frames_q[base]);
        end
        checks++; if (last_low !== 132) begin fails++; $display("FAIL basic_ncs_low: got %0d expected 132", last_low); end
        checks++; if (last_rises !== 16) begin fails++; $display("FAIL basic_rises: got %0d expected 16", last_rises); end
    endtask

    task automatic test_read_frame;
        int n;
        int k = 0;
        int bad = 0;
        int base = frames_q.size();
        start(1'b0, 7'h7F, 8'hFF);
        while (ncs !== 1'b1 && k < 300) begin
            tick_s;
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            if (copi !== 1'b0 || sclk !== 1'b0 || ncs !== 1'b1 || done !== 1'b0) bad++;
            if (i < 3) tick_s;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL read_gap_idle: got %0d bad gap cycles expected 0", bad); end
        wait_done(0, n);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL read_done: got %b expected 1", done); end
        checks++; if (frames_q[base] !== 16'h7FFF) begin
            fails++; $display("FAIL read_frame: got %h expected 7fff", frames_q[base]);
        end
        tick_s;
    endtask

    task automatic test_back_to_back;
        int n;
        int base = frames_q.size();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 7'h01;
        req_data = 8'h55;
        tick_s;
        req_addr = 7'h02;
        req_data = 8'hAA;
        checks++; if (ncs !== 1'b0) begin fails++; $display("FAIL b2b_first_accept: got ncs=%b expected 0", ncs); end
        wait_done(1, n);
        checks++; if (req_ready !== 1'b1 || n !== 137) begin
            fails++; $display("FAIL b2b_first_done: got ready=%b latency %0d expected 1 and 137", req_ready, n);
        end
        tick_s;
        req_valid = 1'b0;
        checks++; if ({ncs, busy} !== 2'b01) begin
            fails++; $display("FAIL b2b_accept_in_done: got ncs/busy=%b expected 01", {ncs, busy});
        end
        wait_done(1, n);
        checks++; if (frames_q.size() - base !== 2 || frames_q[base] !== 16'h8155 || frames_q[base+1] !== 16'h82AA) begin
            fails++; $display("FAIL b2b_frames: got %0d frames %h %h expected 8155 82aa",
                              frames_q.size() - base, frames_q[base], frames_q[base+1]);
        end
        checks++; if (last_gap < 5) begin fails++; $display("FAIL b2b_gap: got %0d expected >=5", last_gap); end
        tick_s;
    endtask

    task automatic test_busy_interference;
        int n;
        int base = frames_q.size();
        start(1'b1, 7'h01, 8'h03);
        repeat (20) tick_s;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 7'h55;
        req_data = 8'hAA;
        checks++; if ({req_ready, busy} !== 2'b01) begin
            fails++; $display("FAIL busy_ready: got ready/busy=%b expected 01", {req_ready, busy});
        end
        tick_s;
        req_valid = 1'b0;
        wait_done(0, n);
        checks++; if (frames_q[base] !== 16'h8103) begin
            fails++; $display("FAIL busy_frame: got %h expected 8103", frames_q[base]);
        end
        repeat (30) tick_s;
        checks++; if (frames_q.size() - base !== 1 || ncs !== 1'b1) begin
            fails++; $display("FAIL busy_not_queued: got %0d frames ncs=%b expected 1 frame ncs=1", frames_q.size() - base, ncs);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        int k = 0;
        int dn = 0;
        int base;
        start(1'b1, 7'h03, 8'hC3);
        while (rises < 5 && k < 200) begin
            tick_s;
            k++;
        end
        checks++; if (rises !== 5) begin fails++; $display("FAIL rst_mid_rises: got %0d expected 5", rises); end
        rst = 1'b1;
        tick_s;
        checks++; if (ncs !== 1'b1) begin fails++; $display("FAIL rst_mid_ncs: got %b expected 1", ncs); end
        checks++; if (sclk !== 1'b0) begin fails++; $display("FAIL rst_mid_sclk: got %b expected 0", sclk); end
        checks++; if (copi !== 1'b0) begin fails++; $display("FAIL rst_mid_copi: got %b expected 0", copi); end
        checks++; if ({req_ready, busy} !== 2'b10) begin
            fails++; $display("FAIL rst_mid_ready: got ready/busy=%b expected 10", {req_ready, busy});
        end
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (done === 1'b1) dn++;
            tick_s;
        end
        checks++; if (dn !== 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", dn); end
        base = frames_q.size();
        start(1'b0, 7'h2A, 8'h5C);
        wait_done(1, n);
        checks++; if (frames_q[base] !== 16'h2A5C || n !== 137) begin
            fails++; $display("FAIL rst_mid_recover: got %h latency %0d expected 2a5c and 137", frames_q[base], n);
        end
        checks++; if (last_rises !== 16 || last_low !== 132) begin
            fails++; $display("FAIL rst_mid_shape: got rises %0d low %0d expected 16 and 132", last_rises, last_low);
        end
        tick_s;
    endtask

    task automatic test_sampling_margin;
        int n;
        int base = frames_q.size();
        start(1'b1, 7'h25, 8'hA5);
        wait_done(1, n);
        checks++; if (frames_q[base] !== 16'hA5A5) begin
            fails++; $display("FAIL margin_frame: got %h expected a5a5", frames_q[base]);
        end
        checks++; if (margin_err !== 0) begin
            fails++; $display("FAIL margin_copi_stable: got %0d violations expected 0", margin_err);
        end
        tick_s;
    endtask

    initial begin
        test_reset;
        test_basic_write;
        test_read_frame;
        test_back_to_back;
        test_busy_interference;
        test_reset_mid_frame;
        test_sampling_margin;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
